debug_uart_tx: RTL

- Transmit side of the debug-unit host link. Frames debug responses as UART bytes on uart_tx toward the host client.
- Sends OP_OK (0x02) when the command decoder answers a ping.
- Sends OP_SIGNAL (0x01) followed by the CPU PC and a packed signal snapshot after pause, next or breakpoint events.
- Sits inside the debug unit, beside the UART command receiver. It drives the top-level uart_tx pin.

---
 rtl/debug_uart_tx_pkg.sv | 24 ++
 rtl/debug_uart_tx_if.sv | 23 ++
 rtl/uart_byte_tx.sv | 112 +++++++++++
 rtl/debug_uart_tx.sv | 103 ++++++++++
 4 files changed

// File: rtl/debug_uart_tx_pkg.sv
// Shared debug-unit definitions: host-link opcodes, default baud divisor and
// the per-byte transmitter state encoding.
package debug_uart_tx_pkg;

    localparam logic [7:0] OP_NONE    = 8'hFF;
    localparam logic [7:0] OP_SIGNAL  = 8'h01;
    localparam logic [7:0] OP_OK      = 8'h02;
    localparam logic [7:0] OP_PING    = 8'h03;
    localparam logic [7:0] OP_PAUSE   = 8'h04;
    localparam logic [7:0] OP_RESUME  = 8'h05;
    localparam logic [7:0] OP_NEXT    = 8'h06;
    localparam logic [7:0] OP_PROGRAM = 8'h07;

    // 100 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/debug_uart_tx_if.sv
// Request/status bundle between the debug-unit control logic and the
// response transmitter. SIG_BYTES must match the transmitter's parameter.
interface debug_uart_tx_if #(
    parameter int unsigned SIG_BYTES = 4
);
    logic                     send_ok;
    logic                     send_signal;
    logic [31:0]              pc;
    logic [8*SIG_BYTES-1:0]   signals;
    logic                     busy;
    logic                     done;
    logic                     uart_tx;

    modport master (
        output send_ok, send_signal, pc, signals,
        input  busy, done, uart_tx
    );

    modport slave (
        input  send_ok, send_signal, pc, signals,
        output busy, done, uart_tx
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 UART transmitter with a valid/ready byte handshake.
// byte_ready is also high on the last cycle of a stop bit so a queued byte
// starts with no idle gap between frames.
module uart_byte_tx
    import debug_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] data,
    output logic       uart_tx
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_last;

    assign baud_last  = (baud_q == BaudLast);
    assign byte_ready = (state_q == StIdle) || ((state_q == StStop) && baud_last);
    assign uart_tx    = tx_q;

    // Next state, counters and registered line level for the upcoming cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            StIdle: begin
                if (byte_valid) begin
                    state_d = StStart;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = data;
                end
            end
            StStart: begin
                if (baud_last) begin
                    state_d = StData;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (byte_valid) begin
                        state_d = StStart;
                        shift_d = data;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state we are entering so uart_tx is a flop.
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug-unit response transmitter: sequences OP_OK or OP_SIGNAL packets
// (opcode, PC little-endian, signal snapshot little-endian) into the byte
// transmitter. The first byte is handed over on the accept edge itself so
// the start bit appears on the very next edge.
module debug_uart_tx
    import debug_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SIG_BYTES    = 4
) (
    input logic            clk,
    input logic            rst,
    debug_uart_tx_if.slave bus
);

    localparam int unsigned NumBytes = 5 + SIG_BYTES;
    localparam int unsigned IdxW     = $clog2(NumBytes);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumBytes - 1);

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [IdxW-1:0]          last_q, last_d;
    logic [NumBytes-1:0][7:0] shadow_q, shadow_d;

    logic            accept;
    logic            more;
    logic [IdxW-1:0] idx_next;
    logic [IdxW-1:0] sel;
    logic [7:0]      opcode;
    logic [7:0]      byte_data;
    logic            byte_valid;
    logic            byte_ready;
    logic            line;

    // send_signal has priority; requests while busy are dropped.
    assign accept   = !busy_q && (bus.send_ok || bus.send_signal);
    assign opcode   = bus.send_signal ? OP_SIGNAL : OP_OK;
    assign more     = (idx_q != last_q);
    assign idx_next = idx_q + 1'b1;
    // Keep the mux index in range once the last byte is underway.
    assign sel      = more ? idx_next : idx_q;

    assign byte_valid = accept || (busy_q && more);
    assign byte_data  = accept ? opcode : shadow_q[sel];

    // Packet sequencing: capture payload on accept, step the byte index at
    // each stop-bit end, flag completion after the final byte.
    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        last_d   = last_q;
        shadow_d = shadow_q;

        if (accept) begin
            busy_d   = 1'b1;
            idx_d    = '0;
            last_d   = bus.send_signal ? IdxLast : '0;
            shadow_d = {bus.signals, bus.pc, opcode};
        end else if (busy_q && byte_ready) begin
            if (more) begin
                idx_d = idx_next;
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            last_q   <= '0;
            shadow_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .data       (byte_data),
        .uart_tx    (line)
    );

    assign bus.uart_tx = line;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
